// File: rtl/regfile_read_streamer_pkg.sv
// Shared defaults and FSM state encoding for the regfile read streamer.
package regfile_read_streamer_pkg;

  localparam int RF_DATA_WIDTH = 8;
  localparam int RF_ADDR_WIDTH = 12;
  localparam int RF_RD_LAT     = 1;
  localparam int RF_FIFO_DEPTH = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

endpackage

// File: rtl/regfile_read_streamer_fifo.sv
// rd_stream_fifo: synchronous return buffer; push and pop may coincide even when full.
module rd_stream_fifo #(
  parameter int WIDTH = 20,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW:0]      r_wptr;
  logic [PW:0]      r_rptr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (push) r_wptr <= r_wptr + (PW+1)'(1);
      if (pop)  r_rptr <= r_rptr + (PW+1)'(1);
    end
  end

  // NOTE: storage is not reset; only the pointers are, and the top masks the head while empty.
  always_ff @(posedge clk) begin
    if (push) r_mem[r_wptr[PW-1:0]] <= wdata;
  end

  assign rdata = r_mem[r_rptr[PW-1:0]];
  assign count = r_wptr - r_rptr;
  assign empty = (count == '0);
  assign full  = (count == (PW+1)'(DEPTH));

endmodule

// File: rtl/regfile_read_streamer.sv
// regfile_read_streamer: reads LEN entries from BASE and returns them as a valid/ready stream.
// Define REGFILE_RD_ADDR_CHECK_EN to build the returned-address tag checker (addr_err).
module regfile_read_streamer
  import regfile_read_streamer_pkg::*;
#(
  parameter int DATA_WIDTH = RF_DATA_WIDTH,
  parameter int ADDR_WIDTH = RF_ADDR_WIDTH,
  parameter int RD_LAT     = RF_RD_LAT,
  parameter int FIFO_DEPTH = RF_FIFO_DEPTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   len,
  output logic                  busy,
  output logic                  done,
  output logic                  ran_re,
  output logic [ADDR_WIDTH-1:0] ran_r_addr,
  input  logic [DATA_WIDTH-1:0] ran_r_data,
  input  logic [ADDR_WIDTH-1:0] out_ran_r_addr,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic [ADDR_WIDTH-1:0] m_addr,
  output logic                  m_last,
  output logic                  addr_err
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int FW = DATA_WIDTH + ADDR_WIDTH;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [ADDR_WIDTH:0]   r_len;
  logic [ADDR_WIDTH:0]   r_issued;
  logic [ADDR_WIDTH:0]   r_popped;
  logic [RD_LAT-1:0]     r_pend;
  logic                  r_done;

  logic [CW-1:0]         w_count;
  logic [CW-1:0]         w_in_flight;
  logic [CW:0]           w_credit;
  logic [ADDR_WIDTH:0]   w_len_m1;
  logic [FW-1:0]         w_head;
  logic                  w_empty;
  logic                  w_full;
  logic                  w_accept;
  logic                  w_issue;
  logic                  w_final_issue;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_last;

  always_comb begin
    w_in_flight = '0;
    for (int i = 0; i < RD_LAT; i++) w_in_flight = w_in_flight + CW'(r_pend[i]);
  end

  // Reads still in the regfile pipe already own a FIFO slot, so no return can overflow.
  assign w_credit      = {1'b0, w_count} + {1'b0, w_in_flight};
  assign w_len_m1      = r_len - (ADDR_WIDTH+1)'(1);
  assign w_accept      = (r_state == ST_IDLE) && start && (len != '0);
  assign w_issue       = (r_state == ST_ISSUE) && (w_credit < (CW+1)'(FIFO_DEPTH)) && !w_full;
  assign w_final_issue = w_issue && (r_issued == w_len_m1);
  assign w_push        = r_pend[RD_LAT-1];
  assign w_pop         = m_valid && m_ready;
  assign w_last        = !w_empty && (r_popped == w_len_m1);

  // NOTE: next state is defaulted to the current state first so no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (w_accept)        w_state_nxt = ST_ISSUE;
      ST_ISSUE: if (w_final_issue)   w_state_nxt = ST_DRAIN;
      ST_DRAIN: if (w_pop && w_last) w_state_nxt = ST_IDLE;
      default:                       w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_addr   <= '0;
      r_len    <= '0;
      r_issued <= '0;
      r_popped <= '0;
      r_pend   <= '0;
      r_done   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_pend  <= (r_pend << 1) | RD_LAT'(w_issue);
      r_done  <= ((r_state == ST_IDLE) && start && (len == '0)) || (w_pop && w_last);
      if (w_accept) begin
        r_addr   <= base_addr;
        r_len    <= len;
        r_issued <= '0;
        r_popped <= '0;
      end else begin
        if (w_issue) begin
          r_addr   <= r_addr + ADDR_WIDTH'(1);
          r_issued <= r_issued + (ADDR_WIDTH+1)'(1);
        end
        if (w_pop) r_popped <= r_popped + (ADDR_WIDTH+1)'(1);
      end
    end
  end

  rd_stream_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (w_push),
    .wdata ({ran_r_data, out_ran_r_addr}),
    .pop   (w_pop),
    .rdata (w_head),
    .count (w_count),
    .empty (w_empty),
    .full  (w_full)
  );

  assign busy       = (r_state != ST_IDLE);
  assign done       = r_done;
  assign ran_re     = w_issue;
  assign ran_r_addr = r_addr;
  assign m_valid    = !w_empty;
  assign m_data     = m_valid ? w_head[FW-1:ADDR_WIDTH] : '0;
  assign m_addr     = m_valid ? w_head[ADDR_WIDTH-1:0]  : '0;
  assign m_last     = w_last;

`ifdef REGFILE_RD_ADDR_CHECK_EN
  logic [ADDR_WIDTH-1:0] r_pend_addr [RD_LAT];
  logic                  r_addr_err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < RD_LAT; i++) r_pend_addr[i] <= '0;
      r_addr_err <= 1'b0;
    end else begin
      r_pend_addr[0] <= r_addr;
      for (int i = 1; i < RD_LAT; i++) r_pend_addr[i] <= r_pend_addr[i-1];
      if (w_push && (out_ran_r_addr != r_pend_addr[RD_LAT-1])) r_addr_err <= 1'b1;
    end
  end

  assign addr_err = r_addr_err;
`else
  assign addr_err = 1'b0;
`endif

endmodule
